spi_frontend: RTL and testbench

SPI_FRONTEND -- requirements
Module: spi_frontend

---
 rtl/spi_frontend_if.sv | 22 ++
 rtl/spi_frontend.sv | 98 +++++++++
 tb/tb_spi_frontend.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/spi_frontend_if.sv
// SPI pins plus the decoder-side word/strobe bundle of the SPI front end.
// slave = the front end itself, master = whatever drives the SPI pins and tx_data.
interface spi_frontend_if;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [15:0] tx_data;
    logic        data_rdy;
    logic [7:0]  spi_in;
    logic        cs_active;

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, tx_data,
        output spi_miso, data_rdy, spi_in, cs_active
    );

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, tx_data,
        input  spi_miso, data_rdy, spi_in, cs_active
    );
endinterface

// File: rtl/spi_frontend.sv
// Mode-0 SPI slave front end, oversampled in the sys_clk domain: byte receive with data_rdy strobe,
// and a 16-bit sample readout that is armed by a request byte (bit7=1, bit0=0).
module spi_frontend #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    spi_frontend_if.slave bus
);

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sclk_hist, r_cs_hist;
    logic [2:0]             r_rx_cnt;
    logic [7:0]             r_rx_sr;
    logic [7:0]             r_spi_in;
    logic                   r_data_rdy;
    logic [15:0]            r_tx_sr;
    logic                   r_tx_arm;

    logic       w_sclk, w_cs_n, w_mosi, w_cs_low;
    logic       w_rise, w_fall, w_select, w_deselect;
    logic [7:0] w_rx_next;

    // CS_N chain resets high so that releasing reset never looks like a select edge
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_hist <= 1'b0;
            r_cs_hist   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_hist   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk     = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_low   = ~w_cs_n;
    assign w_rise     = w_cs_low & w_sclk & ~r_sclk_hist;
    assign w_fall     = w_cs_low & ~w_sclk & r_sclk_hist;
    assign w_select   = ~w_cs_n & r_cs_hist;
    assign w_deselect = w_cs_n & ~r_cs_hist;
    assign w_rx_next  = {r_rx_sr[6:0], w_mosi};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rx_cnt   <= '0;
            r_rx_sr    <= '0;
            r_spi_in   <= '0;
            r_data_rdy <= 1'b0;
            r_tx_sr    <= '0;
            r_tx_arm   <= 1'b0;
        end else begin
            r_data_rdy <= 1'b0;
            if (w_select) begin
                r_rx_cnt <= '0;
                r_rx_sr  <= '0;
                r_tx_sr  <= '0;
                r_tx_arm <= 1'b0;
            end else if (w_deselect) begin
                r_rx_cnt <= '0;
                r_rx_sr  <= '0;
            end else begin
                if (w_rise) begin
                    r_rx_sr  <= w_rx_next;
                    r_rx_cnt <= r_rx_cnt + 3'd1;
                    if (r_rx_cnt == 3'd7) begin
                        r_spi_in   <= w_rx_next;
                        r_data_rdy <= 1'b1;
                        if (w_rx_next[7] && !w_rx_next[0])
                            r_tx_arm <= 1'b1;
                    end
                end
                // a fall always lands several cycles after the rise that may arm, so no overlap
                if (w_fall) begin
                    if (r_tx_arm) begin
                        r_tx_sr  <= bus.tx_data;
                        r_tx_arm <= 1'b0;
                    end else begin
                        r_tx_sr  <= {r_tx_sr[14:0], 1'b0};
                    end
                end
            end
        end
    end

    assign bus.spi_miso  = w_cs_low & r_tx_sr[15];
    assign bus.data_rdy  = r_data_rdy;
    assign bus.spi_in    = r_spi_in;
    assign bus.cs_active = w_cs_low;

endmodule

// File: tb/tb_spi_frontend.sv
// Directed bench for spi_frontend: table of bytes within one CS frame with expected spi_in/MISO,
// then hand-written abort, reset-mid-byte and back-to-back sequences.
module tb_spi_frontend;
    localparam int SS = 2;

    typedef struct packed {
        logic [7:0]  mosi;
        logic [15:0] tx;
        logic [7:0]  exp_in;
        logic [7:0]  exp_miso;
    } vec_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    spi_frontend_if bus();

    spi_frontend #(.SYNC_STAGES(SS)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int         cyc = 0;
    int         rdy_cnt = 0;
    int         rdy_cyc = 0;
    logic [7:0] rdy_val = '0;
    int         last_rise = 0;
    int         checks = 0;
    int         errors = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk)
        if (bus.data_rdy === 1'b1) begin
            rdy_cnt <= rdy_cnt + 1;
            rdy_val <= bus.spi_in;
            rdy_cyc <= cyc;
        end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // SCLK at sys_clk/8; MISO captured just before each rise, as a mode-0 master would
    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] mb);
        mb = '0;
        for (int i = 0; i < n; i++) begin
            bus.spi_mosi = b[7-i];
            repeat (4) @(negedge sys_clk);
            mb = {mb[6:0], bus.spi_miso};
            bus.spi_sclk = 1'b1;
            last_rise = cyc;
            repeat (4) @(negedge sys_clk);
            bus.spi_sclk = 1'b0;
        end
        repeat (4) @(negedge sys_clk);
    endtask

    vec_t       vecs [12];
    logic [7:0] mb;
    logic [7:0] rb;
    int         n0;
    int         nb2b;

    initial begin
        vecs[0]  = '{8'h5B, 16'h0000, 8'h5B, 8'h00};
        vecs[1]  = '{8'h80, 16'hA5C3, 8'h80, 8'h00};
        vecs[2]  = '{8'h00, 16'hFFFF, 8'h00, 8'hA5};
        vecs[3]  = '{8'h00, 16'hFFFF, 8'h00, 8'hC3};
        vecs[4]  = '{8'h00, 16'hFFFF, 8'h00, 8'h00};
        vecs[5]  = '{8'h81, 16'hFFFF, 8'h81, 8'h00};
        vecs[6]  = '{8'h00, 16'hFFFF, 8'h00, 8'h00};
        vecs[7]  = '{8'hFE, 16'h1234, 8'hFE, 8'h00};
        vecs[8]  = '{8'h7F, 16'h0000, 8'h7F, 8'h12};
        vecs[9]  = '{8'h01, 16'hFFFF, 8'h01, 8'h34};
        vecs[10] = '{8'hFF, 16'hFFFF, 8'hFF, 8'h00};
        vecs[11] = '{8'h5A, 16'hFFFF, 8'h5A, 8'h00};

        bus.spi_sclk = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(negedge sys_clk);
        chk("rst data_rdy", 32'(bus.data_rdy), 0);
        chk("rst spi_in", 32'(bus.spi_in), 0);
        chk("rst miso", 32'(bus.spi_miso), 0);
        chk("rst cs_active", 32'(bus.cs_active), 0);
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);

        // clocks with CS inactive must be ignored
        n0 = rdy_cnt;
        send_bits(8'hFF, 8, mb);
        chk("idle clk no rdy", 32'(rdy_cnt - n0), 0);
        chk("idle clk miso", 32'(mb), 0);

        bus.spi_cs_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        chk("cs_active on", 32'(bus.cs_active), 1);

        for (int v = 0; v < 12; v++) begin
            bus.tx_data = vecs[v].tx;
            n0 = rdy_cnt;
            send_bits(vecs[v].mosi, 8, mb);
            chk($sformatf("vec%0d rdy count", v), 32'(rdy_cnt - n0), 1);
            chk($sformatf("vec%0d spi_in", v), 32'(rdy_val), 32'(vecs[v].exp_in));
            chk($sformatf("vec%0d miso", v), 32'(mb), 32'(vecs[v].exp_miso));
            if (v == 0)
                chk("rdy latency", 32'(rdy_cyc - last_rise), SS + 1);
        end

        bus.spi_cs_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        chk("cs_active off", 32'(bus.cs_active), 0);
        chk("spi_in kept", 32'(bus.spi_in), 32'h5A);
        chk("miso idle", 32'(bus.spi_miso), 0);

        // aborted byte: 5 bits then deselect
        bus.spi_cs_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        n0 = rdy_cnt;
        send_bits(8'hA7, 5, mb);
        bus.spi_cs_n = 1'b1;
        repeat (8) @(negedge sys_clk);
        chk("abort no rdy", 32'(rdy_cnt - n0), 0);
        chk("abort spi_in kept", 32'(bus.spi_in), 32'h5A);
        bus.spi_cs_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        send_bits(8'h3C, 8, mb);
        chk("after abort rdy", 32'(rdy_cnt - n0), 1);
        chk("after abort spi_in", 32'(rdy_val), 32'h3C);
        bus.spi_cs_n = 1'b1;
        repeat (4) @(negedge sys_clk);

        // reset after 4th rise of a byte
        bus.spi_cs_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        n0 = rdy_cnt;
        send_bits(8'hFF, 3, mb);
        bus.spi_mosi = 1'b1;
        repeat (4) @(negedge sys_clk);
        bus.spi_sclk = 1'b1;
        repeat (4) @(negedge sys_clk);
        sys_rst = 1'b1;
        bus.spi_sclk = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("midrst data_rdy", 32'(bus.data_rdy), 0);
        chk("midrst spi_in", 32'(bus.spi_in), 0);
        chk("midrst miso", 32'(bus.spi_miso), 0);
        chk("midrst cs_active", 32'(bus.cs_active), 0);
        repeat (8) @(negedge sys_clk);
        bus.spi_cs_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        chk("midrst no rdy", 32'(rdy_cnt - n0), 0);
        bus.spi_cs_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        send_bits(8'hC6, 8, mb);
        chk("post rst rdy", 32'(rdy_cnt - n0), 1);
        chk("post rst spi_in", 32'(rdy_val), 32'hC6);
        bus.spi_cs_n = 1'b1;
        repeat (4) @(negedge sys_clk);

        // back-to-back random bytes in one frame
        bus.tx_data = '0;
        bus.spi_cs_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        nb2b = rdy_cnt;
        for (int k = 0; k < 64; k++) begin
            rb = 8'($urandom_range(0, 255));
            n0 = rdy_cnt;
            send_bits(rb, 8, mb);
            chk($sformatf("b2b%0d rdy", k), 32'(rdy_cnt - n0), 1);
            chk($sformatf("b2b%0d spi_in", k), 32'(rdy_val), 32'(rb));
        end
        chk("b2b total", 32'(rdy_cnt - nb2b), 64);
        bus.spi_cs_n = 1'b1;
        repeat (4) @(negedge sys_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
